// File: rtl/second_min_search.sv
// second_min_search: scans the per-second accumulation BRAM once per start
// request and reports the bin index (low_time) and value (min_value) of the
// smallest unsigned amplitude; ties resolve to the lowest index.
// Optional build macro SECOND_MIN_CONFIRM_EN: a scan result is only committed
// when its index matches the candidate of the previous completed scan.
module second_min_search #(
    parameter int NUM_BINS     = 250,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              bram_en,
    output logic [7:0]        bram_addr,
    input  logic [DATA_W-1:0] bram_rdata,
    output logic [7:0]        low_time,
    output logic [DATA_W-1:0] min_value,
    output logic              busy,
    output logic              done
);

    localparam logic [7:0] LAST_ADDR  = 8'(NUM_BINS - 1);
    localparam logic [2:0] DRAIN_LAST = 3'(READ_LATENCY);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                w_accept;
    logic                w_finish;
    logic [7:0]          r_cnt;
    logic [2:0]          r_drain_cnt;
    logic                r_bram_en;
    logic [7:0]          r_bram_addr;
    logic [DATA_W-1:0]   r_run_min;
    logic [7:0]          r_run_idx;
    logic [7:0]          r_low_time;
    logic [DATA_W-1:0]   r_min_value;
    logic                r_done;
    logic                r_tag_vld [READ_LATENCY];
    logic [7:0]          r_tag_idx [READ_LATENCY];
    logic                w_hit;
    logic [DATA_W-1:0]   w_cand_min;
    logic [7:0]          w_cand_idx;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state decode; finish marks the last drain cycle (commit point)
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_ISSUE;
                    w_accept     = 1'b1;
                end
            end
            S_ISSUE: begin
                if (r_cnt == LAST_ADDR) w_state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (r_drain_cnt == DRAIN_LAST) begin
                    w_state_next = S_DONE;
                    w_finish     = 1'b1;
                end
            end
            S_DONE: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Address issue and drain counters; address holds once enable drops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_drain_cnt <= '0;
            r_bram_en   <= 1'b0;
            r_bram_addr <= '0;
        end else if (w_accept) begin
            r_cnt       <= '0;
            r_drain_cnt <= '0;
        end else if (r_state == S_ISSUE) begin
            r_bram_en   <= 1'b1;
            r_bram_addr <= r_cnt;
            r_cnt       <= r_cnt + 8'd1;
        end else if (r_state == S_DRAIN) begin
            r_bram_en   <= 1'b0;
            r_drain_cnt <= r_drain_cnt + 3'd1;
        end else begin
            r_bram_en   <= 1'b0;
        end
    end

    // Tag pipeline: follows each registered address until its data returns
    genvar gi;
    generate
        for (gi = 0; gi < READ_LATENCY; gi++) begin : g_tag
            // Shift one stage of the valid/index tag
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_tag_vld[gi] <= 1'b0;
                    r_tag_idx[gi] <= '0;
                end else if (gi == 0) begin
                    r_tag_vld[gi] <= r_bram_en;
                    r_tag_idx[gi] <= r_bram_addr;
                end else begin
                    r_tag_vld[gi] <= r_tag_vld[(gi == 0) ? 0 : gi - 1];
                    r_tag_idx[gi] <= r_tag_idx[(gi == 0) ? 0 : gi - 1];
                end
            end
        end
    endgenerate

    // Strict less-than so an equal later bin never displaces an earlier one
    always_comb begin
        w_hit      = r_tag_vld[READ_LATENCY-1] && (bram_rdata < r_run_min);
        w_cand_min = w_hit ? bram_rdata : r_run_min;
        w_cand_idx = w_hit ? r_tag_idx[READ_LATENCY-1] : r_run_idx;
    end

    // Running minimum, restarted on each accepted scan
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run_min <= '1;
            r_run_idx <= '0;
        end else if (w_accept) begin
            r_run_min <= '1;
            r_run_idx <= '0;
        end else begin
            r_run_min <= w_cand_min;
            r_run_idx <= w_cand_idx;
        end
    end

`ifdef SECOND_MIN_CONFIRM_EN
    logic [7:0] r_prev_candidate;
    logic       r_candidate_valid;

    // Commit only when two consecutive completed scans agree on the index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done            <= 1'b0;
            r_low_time        <= '0;
            r_min_value       <= '1;
            r_prev_candidate  <= '0;
            r_candidate_valid <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_finish) begin
                r_prev_candidate  <= w_cand_idx;
                r_candidate_valid <= 1'b1;
                if (r_candidate_valid && (r_prev_candidate == w_cand_idx)) begin
                    r_low_time  <= w_cand_idx;
                    r_min_value <= w_cand_min;
                end
            end
        end
    end
`else
    // Commit the scan result unconditionally on completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done      <= 1'b0;
            r_low_time  <= '0;
            r_min_value <= '1;
        end else begin
            r_done <= w_finish;
            if (w_finish) begin
                r_low_time  <= w_cand_idx;
                r_min_value <= w_cand_min;
            end
        end
    end
`endif

    assign bram_en   = r_bram_en;
    assign bram_addr = r_bram_addr;
    assign low_time  = r_low_time;
    assign min_value = r_min_value;
    assign done      = r_done;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_second_min_search.sv
// Bench for second_min_search: three instances (read latency 2, 1, 4) share
// one BRAM image; each has its own latency-matched read pipeline.
module tb_second_min_search;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] mem [256];

    logic        en  [3];
    logic [7:0]  adr [3];
    logic [31:0] rd  [3];
    logic [7:0]  lt  [3];
    logic [31:0] mv  [3];
    logic        bsy [3];
    logic        dn  [3];

    logic [31:0] p2 [2];
    logic [31:0] p1 [1];
    logic [31:0] p4 [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    second_min_search #(.NUM_BINS(250), .DATA_W(32), .READ_LATENCY(2)) u_l2 (
        .clk(clk), .rst(rst), .start(start), .bram_en(en[0]), .bram_addr(adr[0]),
        .bram_rdata(rd[0]), .low_time(lt[0]), .min_value(mv[0]), .busy(bsy[0]), .done(dn[0]));
    second_min_search #(.NUM_BINS(250), .DATA_W(32), .READ_LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .start(start), .bram_en(en[1]), .bram_addr(adr[1]),
        .bram_rdata(rd[1]), .low_time(lt[1]), .min_value(mv[1]), .busy(bsy[1]), .done(dn[1]));
    second_min_search #(.NUM_BINS(250), .DATA_W(32), .READ_LATENCY(4)) u_l4 (
        .clk(clk), .rst(rst), .start(start), .bram_en(en[2]), .bram_addr(adr[2]),
        .bram_rdata(rd[2]), .low_time(lt[2]), .min_value(mv[2]), .busy(bsy[2]), .done(dn[2]));

    // BRAM models: data appears READ_LATENCY edges after the address
    always @(posedge clk) begin
        p2[0] <= mem[adr[0]];
        p2[1] <= p2[0];
        p1[0] <= mem[adr[1]];
        p4[0] <= mem[adr[2]];
        for (int i = 1; i < 4; i++) p4[i] <= p4[i-1];
    end
    assign rd[0] = p2[1];
    assign rd[1] = p1[0];
    assign rd[2] = p4[3];

    // Reference: committed outputs and confirm history
    int          exp_lt;
    logic [31:0] exp_mv;
    int          prev_cand;
    bit          cand_valid;
    int          done_cyc [3] = '{253, 252, 255};

    typedef struct {
        int          kind;   // 0 ramp+spot, 1 background+spots, 2 all ones
        int          idx_a;
        int          idx_b;  // -1 when unused
        logic [31:0] val;
        logic [31:0] bg;
        bit          poke;   // pulse start while busy
        int          exp_idx;
        logic [31:0] exp_val;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_lt     = 0;
        exp_mv     = 32'hFFFF_FFFF;
        prev_cand  = 0;
        cand_valid = 0;
    endtask

    // Apply the commit rule to a completed scan's candidate
    task automatic model_commit(input int idx, input logic [31:0] val);
`ifdef SECOND_MIN_CONFIRM_EN
        if (cand_valid && prev_cand == idx) begin
            exp_lt = idx;
            exp_mv = val;
        end
        prev_cand  = idx;
        cand_valid = 1;
`else
        exp_lt = idx;
        exp_mv = val;
`endif
    endtask

    // Minimum over bins 0..249 with the earliest index winning ties
    task automatic model_min(output int idx, output logic [31:0] val);
        idx = 0;
        val = 32'hFFFF_FFFF;
        for (int k = 0; k < 250; k++)
            if (mem[k] < val) begin
                val = mem[k];
                idx = k;
            end
    endtask

    task automatic run_scan(input string tag, input bit poke, input int cidx, input logic [31:0] cval);
        int  ndone [3];
        int  cyc [3];
        int  nexta;
        bit  seq_ok;
        ndone = '{0, 0, 0};
        cyc   = '{-1, -1, -1};
        nexta = 0;
        seq_ok = 1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 1; n <= 300; n++) begin
            @(posedge clk); #1;
            start = (poke && (n == 5 || n == 252)) ? 1'b1 : 1'b0;
            if (n == 1) chk({tag, "_busy"}, 64'(bsy[0]), 64'd1);
            for (int i = 0; i < 3; i++)
                if (dn[i]) begin
                    ndone[i]++;
                    if (cyc[i] < 0) cyc[i] = n;
                end
            if (en[0]) begin
                if (adr[0] != 8'(nexta)) seq_ok = 0;
                nexta++;
            end
        end
        start = 1'b0;
        model_commit(cidx, cval);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_donecyc%0d", tag, i), 64'(cyc[i]), 64'(done_cyc[i]));
            chk($sformatf("%s_ndone%0d", tag, i), 64'(ndone[i]), 64'd1);
            chk($sformatf("%s_lt%0d", tag, i), 64'(lt[i]), 64'(exp_lt));
            chk($sformatf("%s_mv%0d", tag, i), 64'(mv[i]), 64'(exp_mv));
        end
        chk({tag, "_addrseq"}, 64'(seq_ok && nexta == 250), 64'd1);
        chk({tag, "_addrhold"}, 64'(adr[0]), 64'd249);
        chk({tag, "_idle"}, 64'(bsy[0]), 64'd0);
        $display("scan %s cand=%0d/%0d low_time=%0d min_value=%0d", tag, cidx, cval, lt[0], mv[0]);
    endtask

    initial begin
        int          ci;
        logic [31:0] cv;
        int          nd;

        vecs[0] = '{0, 137, -1, 32'd10,  32'd0,   1'b1, 137, 32'd10};
        vecs[1] = '{1, 40,  200, 32'd7,  32'd100, 1'b0, 40,  32'd7};
        vecs[2] = '{1, 0,   -1, 32'd3,   32'd50,  1'b0, 0,   32'd3};
        vecs[3] = '{1, 249, -1, 32'd3,   32'd50,  1'b0, 249, 32'd3};
        vecs[4] = '{2, 0,   -1, 32'd0,   32'd0,   1'b0, 0,   32'hFFFF_FFFF};
        vecs[5] = '{1, 60,  -1, 32'd1,   32'd9,   1'b0, 60,  32'd1};
        vecs[6] = '{1, 61,  -1, 32'd1,   32'd9,   1'b0, 61,  32'd1};
        vecs[7] = '{1, 61,  -1, 32'd2,   32'd9,   1'b0, 61,  32'd2};
        vecs[8] = '{1, 90,  -1, 32'd1,   32'd9,   1'b0, 90,  32'd1};

        model_reset();
        for (int k = 0; k < 256; k++) mem[k] = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_lt", 64'(lt[0]), 64'd0);
        chk("rst_mv", 64'(mv[0]), 64'hFFFF_FFFF);
        chk("rst_busy", 64'(bsy[0]), 64'd0);
        chk("rst_done", 64'(dn[0]), 64'd0);
        chk("rst_en", 64'(en[0]), 64'd0);
        chk("rst_addr", 64'(adr[0]), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < 9; v++) begin
            for (int k = 0; k < 256; k++) begin
                case (vecs[v].kind)
                    0:       mem[k] = 32'(1000 - k);
                    1:       mem[k] = vecs[v].bg;
                    default: mem[k] = 32'hFFFF_FFFF;
                endcase
            end
            // Bins past the scan range hold zero so an over-read shows up
            for (int k = 250; k < 256; k++) mem[k] = 32'd0;
            if (vecs[v].kind != 2) mem[vecs[v].idx_a] = vecs[v].val;
            if (vecs[v].idx_b >= 0) mem[vecs[v].idx_b] = vecs[v].val;
            run_scan($sformatf("vec%0d", v), vecs[v].poke, vecs[v].exp_idx, vecs[v].exp_val);
            repeat (2) @(posedge clk);
            #1;
        end

        // Reset in the middle of a scan: no done, outputs back to reset values
        for (int k = 0; k < 250; k++) mem[k] = 32'd500;
        mem[20] = 32'd5;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("abort_lt%0d", i), 64'(lt[i]), 64'd0);
            chk($sformatf("abort_mv%0d", i), 64'(mv[i]), 64'hFFFF_FFFF);
            chk($sformatf("abort_busy%0d", i), 64'(bsy[i]), 64'd0);
            chk($sformatf("abort_en%0d", i), 64'(en[i]), 64'd0);
        end
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        nd = 0;
        for (int n = 0; n < 300; n++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) if (dn[i]) nd++;
        end
        chk("abort_nodone", 64'(nd), 64'd0);
        $display("abort scan low_time=%0d min_value=%0h", lt[0], mv[0]);

        // Randomized images against the reference minimum
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < 256; k++) mem[k] = $urandom_range(0, 400) + 32'd20;
            if (r == 4) mem[$urandom_range(0, 249)] = 32'd0;
            model_min(ci, cv);
            run_scan($sformatf("rand%0d", r), 1'b0, ci, cv);
            repeat (2) @(posedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/second_min_search.md
Name: second_min_search

Overview:
- Scans the per-second accumulation BRAM (250 bins, 4 ms each) once per trigger and finds the bin holding the minimum carrier amplitude.
- The MSF carrier-off edge marks the start of the second, so that bin index is the second phase.
- Its low_time output drives the low_time input of the timing/address-counter stage.
- It owns a read port of the second BRAM and arbitrates nothing else.

Parameters:
- NUM_BINS, 250, number of bins scanned per pass; addresses 0..NUM_BINS-1; must be ≤256.
- DATA_W, 32, width of a BRAM word (unsigned accumulated amplitude).
- READ_LATENCY, 2, cycles from bram_en/bram_addr to valid bram_rdata; legal range 1..4.

Ports:
- clk  in  1  system clock (adc_clk domain).
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle scan request; accepted only in IDLE.
- bram_en  out  1  BRAM read enable.
- bram_addr  out  8  BRAM read address.
- bram_rdata  in  DATA_W  BRAM read data, valid READ_LATENCY cycles after the address.
- low_time  out  8  index of the minimum bin from the last completed scan.
- min_value  out  DATA_W  value of that minimum bin.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse when low_time/min_value update.

Behaviour:
- Reset values (asynchronous):
  - low_time=0, min_value=all ones, busy=0, done=0, bram_en=0, bram_addr=0.
  - FSM goes to IDLE and the pipeline valid bits clear.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE: start=1 moves to ISSUE; busy=1 from the next cycle.
  - ISSUE: bram_en=1; bram_addr counts 0..NUM_BINS-1, one address per cycle. After issuing NUM_BINS-1, go to DRAIN.
  - DRAIN: bram_en=0; wait READ_LATENCY cycles for in-flight reads, then go to DONE.
  - DONE: done=1 for exactly one cycle; low_time/min_value take the running result this cycle. Return to IDLE; busy=0 in IDLE.
- Pipeline tagging: a READ_LATENCY-deep shift register carries a valid bit and the 8-bit index with each issued address. A compare happens only when the tag is valid.
- Compare rules:
  - Running min resets to all ones and running index to 0 at start acceptance.
  - Unsigned strict less-than, so on ties the lowest index wins.
  - If all bins equal all ones, the result is index 0 with value all ones.
- Latency: start sampled at edge 0 → bram_addr=0 at cycle 1 → last address at cycle NUM_BINS → last data at cycle NUM_BINS+READ_LATENCY → done at cycle NUM_BINS+READ_LATENCY+1 (253 with defaults).
- start while busy (ISSUE/DRAIN/DONE) is ignored and not queued.
- low_time and min_value hold between scans; they change only in DONE.
- Reset mid-scan aborts immediately: no done pulse, outputs return to reset values.
- bram_addr holds its last value when bram_en=0.

Optional Feature:
- Macro: SECOND_MIN_CONFIRM_EN.
- Defined:
  - A new candidate index is committed to low_time/min_value only if it equals the candidate from the immediately preceding completed scan; otherwise outputs hold.
  - done still pulses every scan.
  - Adds an 8-bit prev_candidate register and a candidate_valid flag, both cleared by reset; candidate_valid=0 means the first scan never commits.
- Not defined: every scan commits unconditionally.

Test Plan:
- Reset then start with bin k=value 1000−k, others 5000, except bin 137=10 → done at cycle 253 after start; low_time=137, min_value=10; bram_addr sequence 0..249 contiguous.
- Bins 40 and 200 both =7, others 100 → low_time=40 (tie to lowest index).
- start pulsed again at cycles 5 and 252 of a scan → exactly one done; next start after return to IDLE gives a second done 253 cycles later.
- Assert rst at cycle 100 of a scan → done never pulses; low_time=0, min_value=0xFFFFFFFF, busy=0, bram_en=0 within the reset cycle.
- READ_LATENCY=1 and 4 with the minimum in bin 0 and in bin 249 → correct index each time; done at cycle 252 and 255 respectively.
- SECOND_MIN_CONFIRM_EN: scans with minima at 60, 61, 61, 90 → low_time stays 0, 0, then 61, 61.
